// File: rtl/pdp11_irq_pkg.sv
// Shared definitions for the interrupt arbiter and the CPU trap-priority logic.
//   IPL_W         width of an interrupt priority level
//   VEC_W         width of a vector byte address
//   arb_state_t   acknowledge sequencer states
//   level_onehot  level -> 8-bit one-hot (bit L set for level L)
package pdp11_irq_pkg;

    localparam int IPL_W = 3;
    localparam int VEC_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARB,
        ST_RESP,
        ST_WAIT
    } arb_state_t;

    function automatic logic [7:0] level_onehot(input logic [IPL_W-1:0] level);
        level_onehot = 8'b1 << level;
    endfunction

endpackage

// File: rtl/irq_pick.sv
// Combinational lowest-index priority encoder.
// Ports:
//   i_elig   [N]      candidate mask
//   o_found           any bit of i_elig set
//   o_idx    [IDX_W]  index of the lowest set bit (0 when none)
module irq_pick #(
    parameter  int N     = 8,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_elig,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    // Scanning downward lets the lowest set index be written last.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_elig[i]) begin
                o_found = 1'b1;
                o_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_arbiter.sv
// Device-side interrupt arbiter: folds per-source requests into the per-level
// asserting vector and answers CPU acknowledges with the winning vector.
// Optional build macro: IRQ_MASK_EN (adds irq_mask; masked sources keep
// pending but are hidden from asserting and from arbitration).
// Ports:
//   clk, reset_n          clock, async active-low reset
//   irq_req  [NUM_SRC]    request lines, rising edge sets pending
//   irq_clr  [NUM_SRC]    software cancel of pending
//   irq_mask [NUM_SRC]    (IRQ_MASK_EN only) hide source when 1
//   asserting [8]         bit L: some eligible pending source at level L
//   int_ack, int_ipl      CPU acknowledge and level being acknowledged
//   int_vector [9]        vector of the granted source, 0 on nak
//   int_done, int_nak     completion strobe, no-match flag
//   irq_granted [NUM_SRC] one-cycle grant strobe to the device
//
// state   | meaning
// IDLE    | waiting for int_ack, latch int_ipl on entry to ARB
// ARB     | pick lowest pending source at latched level, register it
// RESP    | int_done strobe, grant/clear or nak
// WAIT    | hold until the CPU drops int_ack
module irq_arbiter
    import pdp11_irq_pkg::*;
#(
    parameter int                         NUM_SRC    = 8,
    parameter logic [NUM_SRC*IPL_W-1:0]   SRC_LEVEL  = {NUM_SRC{3'd4}},
    parameter logic [NUM_SRC*VEC_W-1:0]   SRC_VECTOR = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] irq_req,
    input  logic [NUM_SRC-1:0] irq_clr,
`ifdef IRQ_MASK_EN
    input  logic [NUM_SRC-1:0] irq_mask,
`endif
    output logic [7:0]         asserting,
    input  logic               int_ack,
    input  logic [IPL_W-1:0]   int_ipl,
    output logic [VEC_W-1:0]   int_vector,
    output logic               int_done,
    output logic               int_nak,
    output logic [NUM_SRC-1:0] irq_granted
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    arb_state_t         r_state;
    arb_state_t         w_state_n;
    logic [NUM_SRC-1:0] r_req_q;
    logic [NUM_SRC-1:0] r_pend;
    logic [7:0]         r_assert;
    logic [IPL_W-1:0]   r_ipl;
    logic [IDX_W-1:0]   r_idx;
    logic               r_found;
    logic [VEC_W-1:0]   r_vector;

    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_elig;
    logic [NUM_SRC-1:0] w_lvl_hit;
    logic [NUM_SRC-1:0] w_match;
    logic [NUM_SRC-1:0] w_grant;
    logic [7:0]         w_assert_n;
    logic               w_found;
    logic [IDX_W-1:0]   w_idx;
    logic [VEC_W-1:0]   w_pick_vec;

    assign w_rise = irq_req & ~r_req_q;

`ifdef IRQ_MASK_EN
    assign w_elig = r_pend & ~irq_mask;
`else
    assign w_elig = r_pend;
`endif

    // Level-0 sources are never eligible, even if the CPU acknowledges level 0.
    always_comb begin
        w_lvl_hit  = '0;
        w_assert_n = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_lvl_hit[i] = (SRC_LEVEL[i*IPL_W +: IPL_W] == r_ipl) &&
                           (SRC_LEVEL[i*IPL_W +: IPL_W] != '0);
            if (w_elig[i])
                w_assert_n = w_assert_n | level_onehot(SRC_LEVEL[i*IPL_W +: IPL_W]);
        end
        w_assert_n[0] = 1'b0;
    end

    assign w_match = w_elig & w_lvl_hit;

    irq_pick #(.N(NUM_SRC)) u_pick (
        .i_elig  (w_match),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    always_comb begin
        w_pick_vec = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_idx == IDX_W'(i))
                w_pick_vec = SRC_VECTOR[i*VEC_W +: VEC_W];
        end
    end

    // Grant uses the index registered in ARB, so a clear during ARB cannot
    // cancel a grant already decided.
    always_comb begin
        w_grant = '0;
        for (int i = 0; i < NUM_SRC; i++)
            w_grant[i] = (r_state == ST_RESP) && r_found && (r_idx == IDX_W'(i));
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            ST_IDLE: if (int_ack) w_state_n = ST_ARB;
            ST_ARB:  w_state_n = ST_RESP;
            ST_RESP: w_state_n = ST_WAIT;
            ST_WAIT: if (!int_ack) w_state_n = ST_IDLE;
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_req_q  <= '0;
            r_pend   <= '0;
            r_assert <= '0;
            r_ipl    <= '0;
            r_idx    <= '0;
            r_found  <= 1'b0;
            r_vector <= '0;
        end else begin
            r_state  <= w_state_n;
            r_req_q  <= irq_req;
            // New edge wins over clear/grant so a simultaneous request re-pends.
            r_pend   <= (r_pend & ~(irq_clr | w_grant)) | w_rise;
            r_assert <= w_assert_n;
            if (r_state == ST_IDLE && int_ack)
                r_ipl <= int_ipl;
            if (r_state == ST_ARB) begin
                r_idx    <= w_idx;
                r_found  <= w_found;
                r_vector <= w_found ? w_pick_vec : '0;
            end
        end
    end

    assign asserting   = r_assert;
    assign int_vector  = r_vector;
    assign int_done    = (r_state == ST_RESP);
    assign int_nak     = (r_state == ST_RESP) && !r_found;
    assign irq_granted = w_grant;

endmodule

// File: tb/tb_irq_arbiter.sv
module tb_irq_arbiter;

    typedef struct {
        logic [8:0] vec;
        logic       nak;
        logic [7:0] gnt;
    } exp_t;

    // Source table: level and vector per source index.
    int         lvl_tab [8] = '{3, 4, 5, 2, 4, 7, 0, 1};
    logic [8:0] vec_tab [8] = '{9'o064, 9'o100, 9'o060, 9'o070,
                                9'o104, 9'o200, 9'o230, 9'o220};

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] irq_req = '0;
    logic [7:0] irq_clr = '0;
    logic [7:0] irq_mask = '0;
    logic       int_ack = 1'b0;
    logic [2:0] int_ipl = '0;
    logic [7:0] asserting;
    logic [8:0] int_vector;
    logic       int_done;
    logic       int_nak;
    logic [7:0] irq_granted;

    int   n_chk = 0;
    int   n_bad = 0;
    exp_t sb[$];
    logic [7:0] mdl_pend = '0;

    always #5 clk = ~clk;

    irq_arbiter #(
        .NUM_SRC    (8),
        .SRC_LEVEL  ({3'd1, 3'd0, 3'd7, 3'd4, 3'd2, 3'd5, 3'd4, 3'd3}),
        .SRC_VECTOR ({9'o220, 9'o230, 9'o200, 9'o104, 9'o070, 9'o060, 9'o100, 9'o064})
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .irq_req     (irq_req),
        .irq_clr     (irq_clr),
`ifdef IRQ_MASK_EN
        .irq_mask    (irq_mask),
`endif
        .asserting   (asserting),
        .int_ack     (int_ack),
        .int_ipl     (int_ipl),
        .int_vector  (int_vector),
        .int_done    (int_done),
        .int_nak     (int_nak),
        .irq_granted (irq_granted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] mdl_assert();
        logic [7:0] a = '0;
        for (int i = 0; i < 8; i++)
            if (mdl_pend[i] && !irq_mask[i] && lvl_tab[i] != 0)
                a[lvl_tab[i]] = 1'b1;
        return a;
    endfunction

    task automatic pulse(input logic [7:0] m);
        irq_req  = m;
        mdl_pend = mdl_pend | m;
        tick();
        irq_req  = '0;
    endtask

    // Expected answer from the model; the model retires the winner at once.
    task automatic mdl_pick(input int ipl, output exp_t e);
        e.vec = '0;
        e.nak = 1'b1;
        e.gnt = '0;
        for (int i = 7; i >= 0; i--) begin
            if (mdl_pend[i] && !irq_mask[i] && lvl_tab[i] == ipl && ipl != 0) begin
                e.vec = vec_tab[i];
                e.nak = 1'b0;
                e.gnt = 8'(1 << i);
            end
        end
        mdl_pend = mdl_pend & ~e.gnt;
    endtask

    task automatic do_ack(input int ipl, input int race, input bit early);
        exp_t e;
        int   n;
        mdl_pick(ipl, e);
        sb.push_back(e);
        int_ack = 1'b1;
        int_ipl = 3'(ipl);
        for (n = 1; n <= 8; n++) begin
            tick();
            if (early && n == 1) int_ack = 1'b0;
            if (int_done) break;
        end
        chk("done_latency", n, 2);
        if (race >= 0) begin
            irq_req[race]  = 1'b1;
            mdl_pend[race] = 1'b1;
        end
        int_ack = 1'b0;
        tick();
        irq_req = '0;
        tick();
        chk("vec_hold", int_vector, e.vec);
    endtask

    always @(negedge clk) begin
        if (reset_n && int_done) begin
            if (sb.size() == 0) begin
                chk("unexp_done", int_done, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("vector", int_vector, e.vec);
                chk("nak", int_nak, e.nak);
                chk("granted", irq_granted, e.gnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with requests held high: nothing may leak out.
        irq_req = '1;
        tick(); tick();
        chk("rst_assert", asserting, 8'h00);
        chk("rst_vector", int_vector, 9'h000);
        chk("rst_done", {int_done, int_nak}, 2'b00);
        chk("rst_granted", irq_granted, 8'h00);
        irq_req = '0;
        tick();
        reset_n = 1'b1;
        tick(); tick(); tick();
        chk("idle_assert", asserting, 8'h00);

        // Single source at level 5.
        pulse(8'h04);
        chk("assert_lat", asserting, 8'h00);
        tick();
        chk("single_assert", asserting, 8'h20);
        do_ack(5, -1, 1'b0);
        chk("single_clear", asserting, mdl_assert());

        // Same-level tie: lowest index wins, then the other.
        pulse(8'h12);
        tick();
        chk("tie_assert", asserting, 8'h10);
        do_ack(4, -1, 1'b0);
        chk("tie_after1", asserting, 8'h10);
        do_ack(4, -1, 1'b0);
        chk("tie_after2", asserting, mdl_assert());

        // Nak with an unrelated source left pending.
        pulse(8'h01);
        tick();
        do_ack(6, -1, 1'b0);
        chk("nak_pend", asserting, 8'h08);

        // Race: new edge on src 3 during its own grant re-pends it.
        pulse(8'h08);
        tick();
        chk("race_pre", asserting, 8'h0C);
        do_ack(2, 3, 1'b0);
        tick();
        chk("race_post", asserting, 8'h0C);
        do_ack(2, -1, 1'b0);
        do_ack(3, -1, 1'b0);
        chk("race_clean", asserting, 8'h00);

        // Software cancel, level 7, level 0 and early ack drop.
        pulse(8'h80);
        irq_clr = 8'h80;
        mdl_pend[7] = 1'b0;
        tick();
        irq_clr = '0;
        tick();
        chk("clr_assert", asserting, mdl_assert());
        do_ack(1, -1, 1'b0);
        pulse(8'h60);
        tick();
        chk("lvl7_assert", asserting, 8'h80);
        do_ack(0, -1, 1'b0);
        do_ack(7, -1, 1'b1);
        chk("lvl7_clear", asserting, 8'h00);

        // Reset in the middle of an acknowledge.
        pulse(8'h01);
        tick();
        int_ack = 1'b1;
        int_ipl = 3'd3;
        tick();
        reset_n = 1'b0;
        #1;
        chk("abort_done", int_done, 1'b0);
        chk("abort_assert", asserting, 8'h00);
        int_ack = 1'b0;
        mdl_pend = '0;
        tick();
        reset_n = 1'b1;
        tick(); tick(); tick();
        chk("abort_idle", asserting, 8'h00);
        do_ack(3, -1, 1'b0);

`ifdef IRQ_MASK_EN
        // Masked source keeps pending but is hidden.
        pulse(8'h01);
        irq_mask = 8'h01;
        tick(); tick();
        chk("mask_hide", asserting, 8'h00);
        do_ack(3, -1, 1'b0);
        irq_mask = 8'h00;
        tick();
        chk("mask_expose", asserting, 8'h08);
        do_ack(3, -1, 1'b0);
`endif

        tick(); tick();
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
